// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, state and sizing definitions for the 8-bit RISC core
package cpu_pkg;

    localparam int WAIT_MAX_DEF = 16;
    localparam int CNT_W_DEF    = 16;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_HALT = 4'b1111;
    localparam logic [3:0] OP_LD   = 4'b1100;
    localparam logic [3:0] OP_ST   = 4'b1101;
    localparam logic [3:0] OP_BR   = 4'b1001;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// rtl/bus_wait_timer.sv - counts cycles spent waiting for a memory ack
module bus_wait_timer #(
    parameter int WAIT_MAX = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_tick,
    output logic o_timeout
);

    localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_tick) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Fires on the last permitted wait cycle; an ack in that same cycle still wins upstream.
    assign o_timeout = (r_cnt == CW'(WAIT_MAX - 1));

endmodule

// File: rtl/cpu_ctrl_seq.sv
// rtl/cpu_ctrl_seq.sv - multi-cycle fetch/decode/exec/mem/wb control sequencer
module cpu_ctrl_seq
    import cpu_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       opcode,
    input  logic             br_taken,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             resume,
    output logic             en_Fetch,
    output logic             imem_req,
    output logic             ir_load,
    output logic             en_Decode,
    output logic             en_Exec,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             halted,
    output logic             err,
    output logic [2:0]       state_dbg,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_op_q;
    logic [CNT_W-1:0] r_instr_cnt;
    logic             w_tick;
    logic             w_timeout;
    logic             w_clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_FETCH;
            r_op_q      <= '0;
            r_instr_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op_q <= opcode;
            end
            if (pc_inc || pc_load) begin
                r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            end
        end
    end

    assign w_clear = (w_next != r_state);

    bus_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_clear   (w_clear),
        .i_tick    (w_tick),
        .o_timeout (w_timeout)
    );

    always_comb begin
        w_next    = r_state;
        w_tick    = 1'b0;
        en_Fetch  = 1'b0;
        imem_req  = 1'b0;
        ir_load   = 1'b0;
        en_Decode = 1'b0;
        en_Exec   = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        halted    = 1'b0;
        err       = 1'b0;
        case (r_state)
            S_FETCH: begin
                en_Fetch = 1'b1;
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_load = 1'b1;
                    w_next  = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end else begin
                    w_tick = 1'b1;
                end
            end
            S_DECODE: begin
                en_Decode = 1'b1;
                w_next    = S_EXEC;
            end
            S_EXEC: begin
                en_Exec = 1'b1;
                if (is_mem_op(r_op_q)) begin
                    w_next = S_MEM;
                end else begin
                    case (r_op_q)
                        OP_NOP: begin
                            pc_inc = 1'b1;
                            w_next = S_FETCH;
                        end
                        OP_HALT: begin
                            pc_inc = 1'b1;
                            w_next = S_HALT;
                        end
                        OP_BR: begin
                            pc_load = br_taken;
                            pc_inc  = !br_taken;
                            w_next  = S_FETCH;
                        end
                        default: w_next = S_WB;
                    endcase
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (r_op_q == OP_ST);
                if (dmem_ack) begin
                    if (r_op_q == OP_ST) begin
                        pc_inc = 1'b1;
                        w_next = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end else begin
                    w_tick = 1'b1;
                end
            end
            S_WB: begin
                rf_we  = 1'b1;
                pc_inc = 1'b1;
                w_next = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (resume) begin
                    w_next = S_FETCH;
                end
            end
            S_ERR: begin
                err = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    assign state_dbg = r_state;
    assign instr_cnt = r_instr_cnt;

endmodule
